// File: rtl/bus_arbiter_if.sv
// Bus arbiter handshake bundle.
// The "master" view belongs to the requesting side (masters, slaves, bench).
// The "slave" view belongs to the arbiter that serves those requests.
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_WIDTH   = 2
);
  logic [NUM_MASTERS-1:0] b_request;
  logic                   b_util;
  logic                   slave_busy;
  logic [NUM_MASTERS-1:0] b_grant;
  logic [IDX_WIDTH-1:0]   cur_master;
  logic                   bus_busy;
  logic                   grant_timeout;
  logic                   tenure_abort;

  modport master (
    output b_request, b_util, slave_busy,
    input  b_grant, cur_master, bus_busy, grant_timeout, tenure_abort
  );

  modport slave (
    input  b_request, b_util, slave_busy,
    output b_grant, cur_master, bus_busy, grant_timeout, tenure_abort
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin serial-bus arbiter.
// A granted master must raise b_util within GRANT_WAIT cycles and may hold it
// for at most MAX_TENURE cycles. Every release costs a single all-zero grant
// cycle. The RELEASE state also arbitrates, so back-to-back requesters see
// exactly one turnaround cycle between grants. All outputs are registered.
module bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_WIDTH   = 2,
  parameter int GRANT_WAIT  = 4,
  parameter int MAX_TENURE  = 255
) (
  input  logic        clk,
  input  logic        rstn,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BUSY,
    ST_RELEASE
  } state_e;

  // Counters stop one short of the limit so an 8-bit counter covers
  // MAX_TENURE = 255 without wrapping.
  localparam logic [7:0] WAIT_LAST   = 8'(GRANT_WAIT - 1);
  localparam logic [7:0] TENURE_LAST = 8'(MAX_TENURE - 1);

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_WIDTH-1:0]   cur_master_q;
  logic [IDX_WIDTH-1:0]   last_idx_q;
  logic                   bus_busy_q;
  logic                   grant_timeout_q;
  logic                   tenure_abort_q;
  logic [7:0]             wait_cnt_q;
  logic [7:0]             tenure_cnt_q;

  // Round-robin search results, consumed by the FSM.
  logic [IDX_WIDTH-1:0]   win_base_d;
  logic                   win_valid_d;
  logic [IDX_WIDTH-1:0]   win_idx_d;
  logic [NUM_MASTERS-1:0] win_grant_d;
  logic                   can_grant_d;
  int                     cand;

  // Round-robin winner search.
  // The search starts just after the last served master and wraps around.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // can leave it unassigned and infer a latch.
    win_valid_d = 1'b0;
    win_idx_d   = '0;
    cand        = 0;
    // In RELEASE, last_idx_q has not yet been updated to cur_master_q.
    // Search from cur_master_q directly.
    win_base_d  = (state_q == ST_RELEASE) ? cur_master_q : last_idx_q;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = (int'(win_base_d) + k) % NUM_MASTERS;
      if (!win_valid_d && bus.b_request[cand]) begin
        win_valid_d = 1'b1;
        win_idx_d   = IDX_WIDTH'(cand);
      end
    end
    win_grant_d = NUM_MASTERS'(1) << win_idx_d;
    can_grant_d = win_valid_d && !bus.slave_busy;
  end

  // Arbitration FSM with registered grant, status and pulse outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      state_q         <= ST_IDLE;
      grant_q         <= '0;
      cur_master_q    <= '0;
      last_idx_q      <= IDX_WIDTH'(NUM_MASTERS - 1);
      bus_busy_q      <= 1'b0;
      grant_timeout_q <= 1'b0;
      tenure_abort_q  <= 1'b0;
      wait_cnt_q      <= '0;
      tenure_cnt_q    <= '0;
    end else begin
      grant_timeout_q <= 1'b0;
      tenure_abort_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (can_grant_d) begin
            state_q      <= ST_GRANT;
            grant_q      <= win_grant_d;
            cur_master_q <= win_idx_d;
            bus_busy_q   <= 1'b1;
            wait_cnt_q   <= '0;
          end
        end

        ST_GRANT: begin
          // b_util takes precedence over both a dropped request and an
          // expiring wait.
          if (bus.b_util) begin
            state_q      <= ST_BUSY;
            tenure_cnt_q <= '0;
          end else if (!bus.b_request[cur_master_q]) begin
            state_q <= ST_RELEASE;
            grant_q <= '0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q         <= ST_RELEASE;
            grant_q         <= '0;
            grant_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        ST_BUSY: begin
          // The request line is ignored here; only b_util ends a tenure.
          // A b_util fall on the expiry cycle counts as a normal release.
          if (!bus.b_util) begin
            state_q <= ST_RELEASE;
            grant_q <= '0;
          end else if (tenure_cnt_q == TENURE_LAST) begin
            state_q        <= ST_RELEASE;
            grant_q        <= '0;
            tenure_abort_q <= 1'b1;
          end else begin
            tenure_cnt_q <= tenure_cnt_q + 8'd1;
          end
        end

        ST_RELEASE: begin
          last_idx_q <= cur_master_q;
          if (can_grant_d) begin
            state_q      <= ST_GRANT;
            grant_q      <= win_grant_d;
            cur_master_q <= win_idx_d;
            wait_cnt_q   <= '0;
          end else begin
            state_q    <= ST_IDLE;
            bus_busy_q <= 1'b0;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          grant_q    <= '0;
          bus_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.b_grant       = grant_q;
  assign bus.cur_master    = cur_master_q;
  assign bus.bus_busy      = bus_busy_q;
  assign bus.grant_timeout = grant_timeout_q;
  assign bus.tenure_abort  = tenure_abort_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (3 masters, GRANT_WAIT=4, MAX_TENURE=255).
// Inputs change 1 ns after a rising edge.
// Outputs are observed at that same point, showing the state that edge produced.
module tb_bus_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  bus_arbiter_if #(.NUM_MASTERS(N), .IDX_WIDTH(2)) bus ();

  bus_arbiter #(
    .NUM_MASTERS(N),
    .IDX_WIDTH  (2),
    .GRANT_WAIT (4),
    .MAX_TENURE (255)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int         m;
  logic [2:0] exp_g;

  initial begin
    rstn           = 1'b0;
    bus.b_request  = '0;
    bus.b_util     = 1'b0;
    bus.slave_busy = 1'b0;
    tick(2);
    check("rst_grant", bus.b_grant, 3'b000);
    check("rst_cur", bus.cur_master, 2'd0);
    check("rst_busy", bus.bus_busy, 1'b0);
    check("rst_gto", bus.grant_timeout, 1'b0);
    check("rst_abort", bus.tenure_abort, 1'b0);

    // Request 101 after reset: master 0 first, then master 2 after 0 drops out.
    rstn          = 1'b1;
    bus.b_request = 3'b101;
    tick(1);
    check("first_grant", bus.b_grant, 3'b001);
    check("first_cur", bus.cur_master, 2'd0);
    check("first_busy", bus.bus_busy, 1'b1);
    bus.b_request = 3'b100;
    tick(1);
    check("drop_gap", bus.b_grant, 3'b000);
    check("drop_no_gto", bus.grant_timeout, 1'b0);
    tick(1);
    check("second_grant", bus.b_grant, 3'b100);
    check("second_cur", bus.cur_master, 2'd2);
    bus.b_request = 3'b000;
    tick(2);
    check("back_idle", bus.bus_busy, 1'b0);

    // All masters request; each uses the bus 3 cycles after a 2-cycle wait.
    bus.b_request = 3'b111;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      m     = i % N;
      exp_g = 3'b001 << m;
      check($sformatf("rr_grant%0d", i), bus.b_grant, exp_g);
      check($sformatf("rr_cur%0d", i), bus.cur_master, m);
      tick(1);
      bus.b_util = 1'b1;
      tick(1);
      check($sformatf("rr_hold%0d", i), bus.b_grant, exp_g);
      tick(2);
      bus.b_util = 1'b0;
      tick(1);
      check($sformatf("rr_gap%0d", i), bus.b_grant, 3'b000);
      tick(1);
    end
    check("rr_wrap", bus.b_grant, 3'b010);
    bus.b_request = 3'b000;
    tick(2);

    // Master 1 granted but never drives b_util: timeout after 4 cycles.
    bus.b_request = 3'b010;
    tick(1);
    check("to_grant", bus.b_grant, 3'b010);
    tick(3);
    check("to_still", bus.b_grant, 3'b010);
    check("to_no_pulse_yet", bus.grant_timeout, 1'b0);
    tick(1);
    check("to_dropped", bus.b_grant, 3'b000);
    check("to_pulse", bus.grant_timeout, 1'b1);
    check("to_cur", bus.cur_master, 2'd1);
    bus.b_request = 3'b000;
    tick(1);
    check("to_pulse_end", bus.grant_timeout, 1'b0);
    check("to_cur_kept", bus.cur_master, 2'd1);

    // Tenure abort: master 2 holds b_util, master 0 waits its turn.
    bus.b_request = 3'b101;
    bus.b_util    = 1'b1;
    tick(1);
    check("ten_grant", bus.b_grant, 3'b100);
    tick(255);
    check("ten_hold254", bus.b_grant, 3'b100);
    check("ten_no_abort_yet", bus.tenure_abort, 1'b0);
    tick(1);
    check("ten_dropped", bus.b_grant, 3'b000);
    check("ten_abort", bus.tenure_abort, 1'b1);
    bus.b_request = 3'b001;
    bus.b_util    = 1'b0;
    tick(1);
    check("ten_next", bus.b_grant, 3'b001);
    check("ten_next_cur", bus.cur_master, 2'd0);
    check("ten_abort_end", bus.tenure_abort, 1'b0);
    bus.b_request = 3'b000;
    tick(2);

    // b_util rises on the very cycle GRANT_WAIT expires: b_util wins.
    bus.b_request = 3'b010;
    tick(1);
    check("race_grant", bus.b_grant, 3'b010);
    tick(3);
    bus.b_util = 1'b1;
    tick(1);
    check("race_held", bus.b_grant, 3'b010);
    check("race_no_gto", bus.grant_timeout, 1'b0);
    bus.b_util = 1'b0;
    tick(1);
    check("race_release", bus.b_grant, 3'b000);
    check("race_no_abort", bus.tenure_abort, 1'b0);
    bus.b_request = 3'b000;
    tick(1);

    // b_util falls on the very cycle the tenure expires: normal release.
    bus.b_request = 3'b100;
    tick(1);
    check("tfall_grant", bus.b_grant, 3'b100);
    bus.b_util = 1'b1;
    tick(255);
    check("tfall_hold", bus.b_grant, 3'b100);
    bus.b_util = 1'b0;
    tick(1);
    check("tfall_release", bus.b_grant, 3'b000);
    check("tfall_no_abort", bus.tenure_abort, 1'b0);
    bus.b_request = 3'b000;
    tick(2);

    // slave_busy blocks new grants until it falls.
    bus.slave_busy = 1'b1;
    bus.b_request  = 3'b010;
    tick(3);
    check("sb_blocked", bus.b_grant, 3'b000);
    check("sb_idle", bus.bus_busy, 1'b0);
    bus.slave_busy = 1'b0;
    tick(1);
    check("sb_grant", bus.b_grant, 3'b010);
    bus.b_request = 3'b000;
    tick(2);

    // Reset during BUSY drops the grant on the reset edge.
    bus.b_request = 3'b100;
    tick(1);
    check("rb_grant", bus.b_grant, 3'b100);
    bus.b_util = 1'b1;
    tick(2);
    rstn = 1'b0;
    tick(1);
    check("rb_grant0", bus.b_grant, 3'b000);
    check("rb_busy0", bus.bus_busy, 1'b0);
    check("rb_no_abort", bus.tenure_abort, 1'b0);
    check("rb_cur0", bus.cur_master, 2'd0);
    rstn          = 1'b1;
    bus.b_util    = 1'b0;
    bus.b_request = 3'b111;
    tick(1);
    check("rb_master0_first", bus.b_grant, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
